// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared types and defaults for the DMA word-copy sequencer
package dma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    COPY = 1'b1
  } state_t;

  localparam int WORD_BYTES     = 4;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/dma_copy_ctrl_sync_fifo.sv
// rtl/dma_copy_ctrl_sync_fifo.sv - show-ahead synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic [DATA_WIDTH-1:0]     head,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  full;
  logic                  push_ok;
  logic                  pop_ok;

  // A pop frees a slot on the same edge, so push-while-full is legal only alongside a pop.
  always_comb begin
    full    = (count == FULL_CNT);
    pop_ok  = pop & (count != '0);
    push_ok = push & (~full | pop_ok);
    head    = mem[rd_ptr];
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge ACLK) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dma_copy_ctrl.sv
// rtl/dma_copy_ctrl.sv - word-copy sequencer: reads src, buffers, writes dst, flags done
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDR_WIDTH-1:0] address_src,
  input  logic [ADDR_WIDTH-1:0] address_dst,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  start,
  output logic                  done,
  output logic                  busy,
  output logic                  rd_req_valid,
  input  logic                  rd_req_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_data_valid,
  input  logic [31:0]           rd_data,
  output logic                  wr_req_valid,
  input  logic                  wr_req_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data
);

  localparam int CW = LEN_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WORD_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(WORD_BYTES);

  state_t                 state;
  state_t                 state_nxt;
  logic                   start_q;
  logic                   start_qq;
  logic                   launch;
  logic [ADDR_WIDTH-1:0]  src_q;
  logic [ADDR_WIDTH-1:0]  dst_q;
  logic [CW-1:0]          len_q;
  logic [CW-1:0]          rd_cnt;
  logic [CW-1:0]          rcv_cnt;
  logic [CW-1:0]          wr_cnt;
  logic [CW-1:0]          in_flight;
  logic                   rd_fire;
  logic                   rsp_accept;
  logic                   wr_fire;
  logic                   last_wr;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  // Handshake and event decode; the start edge comes from two flops so no input feeds launch directly.
  always_comb begin
    launch     = (state == IDLE) & start_q & ~start_qq;
    in_flight  = rd_cnt - wr_cnt;
    rd_fire    = rd_req_valid & rd_req_ready;
    rsp_accept = rd_data_valid & (state == COPY) & (rcv_cnt != rd_cnt);
    wr_req_valid = (fifo_count != '0);
    wr_fire    = wr_req_valid & wr_req_ready;
    last_wr    = wr_fire & ((wr_cnt + CW'(1)) == len_q);
    busy       = (state == COPY);
    rd_addr    = src_q + ADDR_WIDTH'(rd_cnt) * WORD_STEP;
    wr_addr    = dst_q + ADDR_WIDTH'(wr_cnt) * WORD_STEP;
  end

  // Next state and read-request decode; reads stop when FIFO_DEPTH words are in flight or buffered.
  always_comb begin
    state_nxt    = state;
    rd_req_valid = 1'b0;
    case (state)
      IDLE: begin
        if (launch && (length != '0)) state_nxt = COPY;
      end
      COPY: begin
        rd_req_valid = (rd_cnt < len_q) && (in_flight < DEPTH_C);
        if (last_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Start edge detector.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      start_q  <= 1'b0;
      start_qq <= 1'b0;
    end else begin
      start_q  <= start;
      start_qq <= start_q;
    end
  end

  // Done flag: cleared by an accepted start (or set at once for a zero-length copy), set by the final write.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)     done <= 1'b0;
    else if (launch)  done <= (length == '0);
    else if (last_wr) done <= 1'b1;
  end

  // Parameter latch and progress counters; parameters are frozen once the copy launches.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      rd_cnt  <= '0;
      rcv_cnt <= '0;
      wr_cnt  <= '0;
    end else if (launch) begin
      src_q   <= address_src & ALIGN_MASK;
      dst_q   <= address_dst & ALIGN_MASK;
      len_q   <= CW'(length);
      rd_cnt  <= '0;
      rcv_cnt <= '0;
      wr_cnt  <= '0;
    end else begin
      if (rd_fire)    rd_cnt  <= rd_cnt + CW'(1);
      if (rsp_accept) rcv_cnt <= rcv_cnt + CW'(1);
      if (wr_fire)    wr_cnt  <= wr_cnt + CW'(1);
    end
  end

  sync_fifo #(
    .DATA_WIDTH (32),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (rsp_accept),
    .push_data (rd_data),
    .pop       (wr_fire),
    .head      (wr_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dma_copy_ctrl.sv
// tb/tb_dma_copy_ctrl.sv - scoreboard bench for dma_copy_ctrl with a behavioural memory model
module tb_dma_copy_ctrl;

  localparam int AW = 32;
  localparam int LW = 16;
  localparam int FD = 4;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] address_src = '0;
  logic [AW-1:0] address_dst = '0;
  logic [LW-1:0] length = '0;
  logic          start = 1'b0;
  logic          done;
  logic          busy;
  logic          rd_req_valid;
  logic          rd_req_ready = 1'b0;
  logic [AW-1:0] rd_addr;
  logic          rd_data_valid = 1'b0;
  logic [31:0]   rd_data = '0;
  logic          wr_req_valid;
  logic          wr_req_ready = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  dma_copy_ctrl #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(FD)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .address_src(address_src), .address_dst(address_dst), .length(length), .start(start),
    .done(done), .busy(busy),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  typedef struct { int due; logic [31:0] d; } rsp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          rd_seen = 0;
  int          wr_seen = 0;
  int          max_lat = 1;
  int          rd_mode = 1;
  int          wr_mode = 1;
  bit          any_valid = 1'b0;
  logic [31:0] salt = '0;
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  rsp_t        pend[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h2545F491) ^ salt;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  always @(posedge ACLK) cyc <= cyc + 1;

  // Read-request monitor: check address order and schedule an in-order response.
  initial forever begin
    @(negedge ACLK);
    if (ARESETN && rd_req_valid && rd_req_ready) begin
      rsp_t r;
      rd_seen++;
      if (exp_rd.size() == 0) chk("rd_unexpected", rd_addr, 32'hxxxxxxxx);
      else                    chk("rd_addr", rd_addr, exp_rd.pop_front());
      r.due = cyc + int'($urandom_range(1, max_lat));
      if (pend.size() != 0 && r.due <= last_due) r.due = last_due + 1;
      last_due = r.due;
      r.d = mem_word(rd_addr);
      pend.push_back(r);
    end
  end

  // Write monitor: compare against the reference write stream.
  initial forever begin
    @(negedge ACLK);
    if (rd_req_valid || wr_req_valid) any_valid = 1'b1;
    if (ARESETN && wr_req_valid && wr_req_ready) begin
      wr_seen++;
      if (exp_wr.size() == 0) chk("wr_unexpected", wr_addr, 32'hxxxxxxxx);
      else begin
        wr_t e;
        e = exp_wr.pop_front();
        chk("wr_addr", wr_addr, e.a);
        chk("wr_data", wr_data, e.d);
      end
    end
  end

  // Memory responder and ready drivers.
  initial forever begin
    @(posedge ACLK);
    #1;
    rd_req_ready = pick(rd_mode);
    wr_req_ready = pick(wr_mode);
    if (!ARESETN) pend.delete();
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      rsp_t r;
      r = pend.pop_front();
      rd_data_valid = 1'b1;
      rd_data = r.d;
    end else begin
      rd_data_valid = 1'b0;
      rd_data = $urandom;
    end
  end

  task automatic launch(input logic [31:0] src, input logic [31:0] dst, input int len);
    int n;
    logic [31:0] s;
    salt = $urandom;
    s = src & 32'hFFFFFFFC;
    for (int i = 0; i < len; i++) begin
      wr_t e;
      exp_rd.push_back(s + 32'(4 * i));
      e.a = (dst & 32'hFFFFFFFC) + 32'(4 * i);
      e.d = mem_word(s + 32'(4 * i));
      exp_wr.push_back(e);
    end
    address_src = src | 32'($urandom_range(0, 3));
    address_dst = dst | 32'($urandom_range(0, 3));
    length = LW'(len);
    start = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    chk("busy_rise", busy, 1);
    chk("done_cleared", done, 0);
    start = 1'b0;
  endtask

  task automatic finish_copy();
    int n;
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    chk("done_set", done, 1);
    chk("busy_end", busy, 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("wr_q_empty", exp_wr.size(), 0);
    tick();
  endtask

  initial begin
    int n;
    int base;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_req_valid, 0);
    chk("rst_wr_valid", wr_req_valid, 0);
    ARESETN = 1'b1;
    repeat (2) tick();

    // zero-length copy
    any_valid = 1'b0;
    address_src = 32'h3000;
    length = '0;
    start = 1'b1;
    n = 0;
    while (!done && n < 6) begin
      tick();
      n++;
    end
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    repeat (4) tick();
    start = 1'b0;
    tick();
    chk("len0_no_valid", any_valid, 0);

    // basic 3-word copy
    rd_mode = 1; wr_mode = 1; max_lat = 1;
    launch(32'h1000, 32'h2000, 3);
    finish_copy();

    // write back-pressure: read-ahead limited to FIFO depth
    wr_mode = 0;
    base = rd_seen;
    launch(32'h0C00, 32'h0E00, 10);
    repeat (30) tick();
    chk("ahead_reads", rd_seen - base, FD);
    chk("ahead_rd_valid", rd_req_valid, 0);
    chk("ahead_wr_valid", wr_req_valid, 1);
    wr_mode = 1;
    finish_copy();

    // address wrap
    rd_mode = 2; wr_mode = 2; max_lat = 3;
    launch(32'hFFFFFFF8, 32'h0100, 4);
    finish_copy();

    // mid-copy start edge and parameter changes are ignored
    launch(32'h4000, 32'h8000, 16);
    repeat (4) tick();
    start = 1'b1;
    address_src = $urandom;
    address_dst = $urandom;
    length = 16'd5;
    repeat (3) tick();
    start = 1'b0;
    length = 16'd7;
    finish_copy();
    launch(32'h5000, 32'h6000, 5);
    finish_copy();

    // reset mid-copy
    rd_mode = 1; wr_mode = 1; max_lat = 1;
    base = wr_seen;
    launch(32'h7000, 32'h9000, 8);
    n = 0;
    while ((wr_seen - base) < 2 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid_progress", wr_seen - base, 2);
    ARESETN = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    pend.delete();
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_valid", rd_req_valid, 0);
    chk("abort_wr_valid", wr_req_valid, 0);
    repeat (2) tick();
    ARESETN = 1'b1;
    tick();
    launch(32'hA000, 32'hB000, 2);
    finish_copy();

    // randomized copies
    for (int k = 0; k < 6; k++) begin
      rd_mode = 2; wr_mode = 2;
      max_lat = int'($urandom_range(1, 4));
      launch($urandom, $urandom, int'($urandom_range(1, 20)));
      finish_copy();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
